// File: rtl/md_pkg.sv
// Shared encodings and defaults for the multiply/divide issue path.
// The controller and the instruction decoder both take their op and state codes from here.
package md_pkg;

    typedef enum logic [2:0] {
        OP_MULTU = 3'd0,
        OP_MULT  = 3'd1,
        OP_DIVU  = 3'd2,
        OP_DIV   = 3'd3,
        OP_MTLO  = 3'd4,
        OP_MTHI  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;
    localparam int CNT_W        = 8;

    // Ops 0-3 go to the multiply/divide unit; 6-7 are reserved and fall through both tests.
    function automatic logic op_is_muldiv(input logic [2:0] op);
        return (op <= OP_DIV);
    endfunction

    function automatic logic op_is_mt(input logic [2:0] op);
        return (op == OP_MTLO) || (op == OP_MTHI);
    endfunction

endpackage

// File: rtl/md_issue_ctrl_if.sv
// Pipeline-side bundle for the multiply/divide issue controller.
// The controller owns the slave view; the pipeline (or a bench) owns the master view.
interface md_issue_ctrl_if;

    logic       E_MdValid;
    logic [2:0] E_MdOp;
    logic       D_MdUse;
    logic       Flush;
    logic       MdBusy;
    logic       Start;
    logic [1:0] Op;
    logic       We;
    logic       HiLo;
    logic       Stall;
    logic       Done;
    logic       SyncErr;

    modport master (
        output E_MdValid, E_MdOp, D_MdUse, Flush, MdBusy,
        input  Start, Op, We, HiLo, Stall, Done, SyncErr
    );

    modport slave (
        input  E_MdValid, E_MdOp, D_MdUse, Flush, MdBusy,
        output Start, Op, We, HiLo, Stall, Done, SyncErr
    );

endinterface

// File: rtl/md_lat_cnt.sv
// Loadable down-counter shadowing the multiply/divide unit latency.
// zero_next flags the last busy cycle, i.e. the count reaches zero on the next edge.
module md_lat_cnt
    import md_pkg::*;
(
    input  logic             Clk,
    input  logic             Rst,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             zero_next
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero_next = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue controller for the multiply/divide unit: issue/write strobes, D-stage stall,
// completion pulse and a sticky check of the shadow counter against the unit's Busy.
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input logic            Clk,
    input logic            Rst,
    md_issue_ctrl_if.slave md
);

    md_state_e        r_state;
    md_state_e        w_state_nxt;
    logic             r_sync_err;
    logic             w_idle;
    logic             w_run;
    logic             w_start;
    logic             w_we;
    logic             w_cnt_last;
    logic             w_done;
    logic             w_sync_bad;
    logic [CNT_W-1:0] w_lat;

    assign w_idle = (r_state == ST_IDLE);
    assign w_run  = (r_state == ST_RUN);

    // Outside IDLE an E-stage request is a bubble; Rst gating keeps strobes quiet during reset.
    assign w_start = Rst & md.E_MdValid & op_is_muldiv(md.E_MdOp) & ~md.Flush & w_idle;
    assign w_we    = Rst & md.E_MdValid & op_is_mt(md.E_MdOp) & ~md.Flush & w_idle;
    assign w_lat   = md.E_MdOp[1] ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);

    md_lat_cnt u_lat_cnt (
        .Clk       (Clk),
        .Rst       (Rst),
        .load      (w_start),
        .value     (w_lat),
        .zero_next (w_cnt_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: if (w_start) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_cnt_last) w_state_nxt = ST_DONE;
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // The unit must be busy exactly while the shadow counter runs.
    assign w_sync_bad = w_run ? ~md.MdBusy : md.MdBusy;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state    <= ST_IDLE;
            r_sync_err <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sync_err <= r_sync_err | w_sync_bad;
        end
    end

    assign md.Start   = w_start;
    assign md.Op      = w_start ? md.E_MdOp[1:0] : 2'd0;
    assign md.We      = w_we;
    assign md.HiLo    = w_we ? md.E_MdOp[0] : 1'b0;
    assign md.Stall   = Rst & md.D_MdUse & (w_start | w_run | md.MdBusy);
    assign md.Done    = w_done;
    assign md.SyncErr = r_sync_err;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: vector table, directed multi-cycle sequences, and a random
// run against a remaining-cycles model of the multiply/divide timeline.
module tb_md_issue_ctrl;

    localparam int ML = 5;
    localparam int DL = 10;

    logic Clk = 1'b0;
    logic Rst;
    always #5 Clk = ~Clk;

    md_issue_ctrl_if bus ();

    md_issue_ctrl #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .md  (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic       v;
        logic [2:0] op;
        logic       du;
        logic       fl;
        logic       bsy;
        logic       rn;
        logic       st;
        logic [1:0] opo;
        logic       we;
        logic       hl;
        logic       sta;
        logic       dn;
        logic       se;
    } vec_t;

    vec_t tbl [12];

    // Model: cycles of unit activity left, a pending completion pulse, sticky error.
    int m_left;
    bit m_done;
    bit m_err;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic st, input logic [1:0] opo,
                           input logic we, input logic hl, input logic sta,
                           input logic dn, input logic se);
        chk($sformatf("%s.Start", tag),   4'(bus.Start),   4'(st));
        chk($sformatf("%s.Op", tag),      4'(bus.Op),      4'(opo));
        chk($sformatf("%s.We", tag),      4'(bus.We),      4'(we));
        chk($sformatf("%s.HiLo", tag),    4'(bus.HiLo),    4'(hl));
        chk($sformatf("%s.Stall", tag),   4'(bus.Stall),   4'(sta));
        chk($sformatf("%s.Done", tag),    4'(bus.Done),    4'(dn));
        chk($sformatf("%s.SyncErr", tag), 4'(bus.SyncErr), 4'(se));
    endtask

    task automatic step(input logic v, input logic [2:0] op, input logic du,
                        input logic fl, input logic bsy, input logic rn);
        @(negedge Clk);
        bus.E_MdValid = v;
        bus.E_MdOp    = op;
        bus.D_MdUse   = du;
        bus.Flush     = fl;
        bus.MdBusy    = bsy;
        Rst           = rn;
        #1;
    endtask

    // Issue one mult/div with D_MdUse held and an ideal Busy; walk it to idle.
    task automatic run_op(input logic [2:0] op, input int lat, input string tag);
        for (int c = 0; c <= lat + 2; c++) begin
            step(c == 0, op, 1'b1, 1'b0, (c >= 1) && (c <= lat), 1'b1);
            chk_all($sformatf("%s.c%0d", tag, c), c == 0, (c == 0) ? op[1:0] : 2'd0,
                    1'b0, 1'b0, c <= lat, c == lat + 1, 1'b0);
        end
    endtask

    task automatic model_clear();
        m_left = 0;
        m_done = 1'b0;
        m_err  = 1'b0;
    endtask

    initial begin
        bus.E_MdValid = 1'b0;
        bus.E_MdOp    = 3'd0;
        bus.D_MdUse   = 1'b0;
        bus.Flush     = 1'b0;
        bus.MdBusy    = 1'b0;
        Rst           = 1'b0;

        //            v  op  du fl bsy rn | st opo we hl sta dn se
        tbl[0]  = '{1, 3'd1, 1, 0, 0, 0,   0, 2'd0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 3'd4, 0, 0, 0, 1,   0, 2'd0, 1, 0, 0, 0, 0};
        tbl[2]  = '{1, 3'd5, 1, 1, 0, 1,   0, 2'd0, 0, 0, 0, 0, 0};
        tbl[3]  = '{1, 3'd5, 1, 0, 0, 1,   0, 2'd0, 1, 1, 0, 0, 0};
        tbl[4]  = '{1, 3'd6, 1, 0, 0, 1,   0, 2'd0, 0, 0, 0, 0, 0};
        tbl[5]  = '{1, 3'd7, 1, 0, 0, 1,   0, 2'd0, 0, 0, 0, 0, 0};
        tbl[6]  = '{0, 3'd1, 1, 0, 0, 1,   0, 2'd0, 0, 0, 0, 0, 0};
        tbl[7]  = '{1, 3'd3, 1, 1, 0, 1,   0, 2'd0, 0, 0, 0, 0, 0};
        tbl[8]  = '{0, 3'd0, 1, 0, 0, 1,   0, 2'd0, 0, 0, 0, 0, 0};
        tbl[9]  = '{0, 3'd0, 1, 0, 1, 1,   0, 2'd0, 0, 0, 1, 0, 0};
        tbl[10] = '{0, 3'd0, 0, 0, 0, 1,   0, 2'd0, 0, 0, 0, 0, 1};
        tbl[11] = '{0, 3'd0, 0, 0, 0, 0,   0, 2'd0, 0, 0, 0, 0, 0};

        repeat (2) @(negedge Clk);
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].v, tbl[i].op, tbl[i].du, tbl[i].fl, tbl[i].bsy, tbl[i].rn);
            chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].opo, tbl[i].we, tbl[i].hl,
                    tbl[i].sta, tbl[i].dn, tbl[i].se);
        end

        run_op(3'd1, ML, "mult");
        run_op(3'd2, DL, "divu");

        // Reset in the middle of a DIV, then a MULT on the first cycle after release.
        step(1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_all("rdiv.c0", 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= 2; c++) begin
            step(1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b1);
            chk_all($sformatf("rdiv.c%0d", c), 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        step(1'b1, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk_all("rdiv.c3", 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(3'd1, ML, "rmult");

        // Busy drops early in a MULT: sticky SyncErr until reset.
        for (int c = 0; c <= 8; c++) begin
            step(c == 0, 3'd1, 1'b0, 1'b0, (c >= 1) && (c <= ML) && (c != 2), 1'b1);
            chk($sformatf("serr.c%0d.SyncErr", c), 4'(bus.SyncErr), 4'(c >= 3));
            chk($sformatf("serr.c%0d.Done", c), 4'(bus.Done), 4'(c == ML + 1));
        end
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("serr.rst.SyncErr", 4'(bus.SyncErr), 4'd0);
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("serr.rel.SyncErr", 4'(bus.SyncErr), 4'd0);

        // Random traffic against the timeline model.
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_clear();
        for (int n = 0; n < 800; n++) begin
            logic       v, du, fl, bsy, rn;
            logic [2:0] op;
            logic       e_st, e_we, e_sta, idle;
            v   = 1'($urandom_range(0, 1));
            op  = 3'($urandom_range(0, 7));
            du  = 1'($urandom_range(0, 1));
            fl  = ($urandom_range(0, 3) == 0);
            rn  = ($urandom_range(0, 60) != 0);
            bsy = (m_left > 0) ^ ($urandom_range(0, 150) == 0);
            step(v, op, du, fl, bsy, rn);
            if (!rn) model_clear();
            idle  = (m_left == 0) && !m_done;
            e_st  = rn && v && (op < 3'd4) && !fl && idle;
            e_we  = rn && v && (op == 3'd4 || op == 3'd5) && !fl && idle;
            e_sta = rn && du && (e_st || m_left > 0 || bsy);
            chk_all($sformatf("rnd%0d", n), e_st, e_st ? op[1:0] : 2'd0, e_we,
                    e_we ? op[0] : 1'b0, e_sta, m_done, m_err);
            if (rn) begin
                if ((m_left > 0) != bsy) m_err = 1'b1;
                if (e_st) begin
                    m_left = op[1] ? DL : ML;
                    m_done = 1'b0;
                end else if (m_left > 0) begin
                    m_left--;
                    m_done = (m_left == 0);
                end else begin
                    m_done = 1'b0;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/md_issue_ctrl.md
MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

Interface
REQ-001 SHALL have parameter MULT_LAT, default 5, meaning the number of busy cycles after a mult issue.
REQ-002 SHALL have parameter DIV_LAT, default 10, meaning the number of busy cycles after a div issue.
REQ-003 SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port E_MdValid, input, 1 bit: the E-stage instruction is a mult/div/mthi/mtlo.
REQ-006 SHALL have port E_MdOp, input, 3 bits: 0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MTLO, 5 MTHI; 6-7 reserved.
REQ-007 SHALL have port D_MdUse, input, 1 bit: the D-stage instruction reads or writes HI/LO (mult/div/mf/mt).
REQ-008 SHALL have port Flush, input, 1 bit: an interrupt or exception kills the E-stage instruction this cycle.
REQ-009 SHALL have port MdBusy, input, 1 bit: the Busy output of the multiply/divide unit.
REQ-010 SHALL have port Start, output, 1 bit: issue pulse to the multiply/divide unit.
REQ-011 SHALL have port Op, output, 2 bits: E_MdOp[1:0] when Start is high, otherwise 0.
REQ-012 SHALL have port We, output, 1 bit: HI/LO write strobe for mthi/mtlo.
REQ-013 SHALL have port HiLo, output, 1 bit: 1 selects HI, 0 selects LO; equals E_MdOp[0] during a We cycle, otherwise 0.
REQ-014 SHALL have port Stall, output, 1 bit: freezes the D stage and inserts a bubble into E.
REQ-015 SHALL have port Done, output, 1 bit: one-cycle pulse when a tracked operation completes.
REQ-016 SHALL have port SyncErr, output, 1 bit: sticky flag set on a shadow-counter versus MdBusy mismatch.

Function
REQ-017 SHALL drive Start and We combinationally: Start = E_MdValid & E_MdOp<4 & ~Flush & state==IDLE; We = E_MdValid & E_MdOp in {4,5} & ~Flush & state==IDLE.
REQ-018 SHALL block both Start and We when Flush is high in the same cycle, so no HI/LO side effect occurs.
REQ-019 SHALL implement the FSM: IDLE -(Start)-> RUN; RUN -(cnt==1)-> DONE; DONE -> IDLE.
REQ-020 SHALL load cnt on the Start edge with MULT_LAT for Op 0/1 and DIV_LAT for Op 2/3, and decrement it every cycle in RUN.
REQ-021 SHALL assert Done for exactly the DONE-state cycle, which is the first cycle with MdBusy low after the operation.
REQ-022 SHALL compute Stall = D_MdUse & (Start | state==RUN | MdBusy).
REQ-023 SHALL NOT stall in the DONE cycle, so mfhi/mflo issued then read the final HI/LO.
REQ-024 SHALL treat E_MdValid while in RUN or DONE as a bubble (no Start, no We); the stall of REQ-022 keeps that case from arising in a correct pipeline.
REQ-025 SHALL set SyncErr when MdBusy is low in RUN, or MdBusy is high in IDLE or DONE; SyncErr clears only on reset.
REQ-026 SHALL treat reserved E_MdOp values 6-7 as no-ops (no Start, no We).

Reset
REQ-027 SHALL, while Rst is low, force state=IDLE, cnt=0, SyncErr=0 and Done=0.
REQ-028 SHALL abandon an in-flight tracked operation if Rst is asserted mid-RUN; after reset release it SHALL accept a new Start on the first edge.
REQ-029 SHALL gate Start, We and Stall low while Rst is low.

Structure
REQ-030 SHALL take the E_MdOp encodings, the IDLE/RUN/DONE state encodings and the MULT_LAT/DIV_LAT defaults from shared package md_pkg, which the decoder also uses.
REQ-031 SHALL place the loadable down-counter in sub-module md_lat_cnt (inputs load, value; output zero-next), instantiated once.

Verification
REQ-032 SHALL cover: MULT issued at cycle 0 with D_MdUse=1 held -> Start=1 at cycle 0, Stall=1 for cycles 0-5, Done=1 at cycle 6, SyncErr=0.
REQ-033 SHALL cover: DIVU issued -> Stall=1 for cycles 0-10, Done=1 at cycle 11, Op=2 at cycle 0.
REQ-034 SHALL cover: MTHI with Flush=1 in the same cycle -> We=0, Start=0, state stays IDLE.
REQ-035 SHALL cover: MTLO with Flush=0 -> We=1, HiLo=0 for one cycle, Stall=0.
REQ-036 SHALL cover: Rst pulsed low at cycle 3 of a DIV -> state=IDLE and Stall=0 immediately; a MULT at the first cycle after release gets Start=1.
REQ-037 SHALL cover: MdBusy forced low at cycle 2 of a MULT -> SyncErr=1 from cycle 3 and held until reset.
